led_scan_sequencer: RTL and testbench
=====================================

LED_SCAN_SEQUENCER -- requirements
Module: led_scan_sequencer

Interface
REQ-001 Parameter SCAN_DWELL, default 4: cycles each card select is held (legal 2..255).
REQ-002 Parameter BLINK_DIV, default 1024: cycles per blink phase (legal 2..65535).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command strobe from the microcontroller.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_card  input  2  target card 0..3.
REQ-008 cmd_mode  input  2  00 off, 01 red, 10 green, 11 red+green.
REQ-009 cmd_blink  input  1  1 = blink the selected colours.
REQ-010 cardSelect  output  2  card index to the LED decoder.
REQ-011 red  output  1  red level for the selected card.
REQ-012 green  output  1  green level for the selected card.

Function
REQ-013 The block SHALL hold one state register per card: {mode[1:0], blink}.
REQ-014 A command SHALL be accepted on any cycle where cmd_valid && cmd_ready; accepted fields go into a one-entry buffer, and cmd_ready SHALL drop the next cycle.
REQ-015 cmd_ready SHALL equal !buf_full; a command cannot be accepted in the cycle the buffer drains, and cmd_valid while not ready SHALL be ignored (no loss of the buffered command).
REQ-016 The scan FSM SHALL have the states HOLD and ADVANCE, and HOLD SHALL count SCAN_DWELL-1 cycles.
REQ-017 On ADVANCE (one cycle), cardSelect SHALL advance 0->1->2->3->0, with wrap from 3 to 0.
REQ-018 The buffer SHALL drain only in ADVANCE, writing the target card register; buf_full clears the same edge.
REQ-019 cardSelect, red and green SHALL be registered and change on the same edge, so they are never skewed.
REQ-020 red/green SHALL equal mode[0]/mode[1] of the card presented, gated by blink phase (REQ-029).
REQ-021 An update to card N SHALL become visible the next time N is presented; worst-case latency from acceptance is 5*SCAN_DWELL+2 cycles.
REQ-022 Each card SHALL be presented for exactly SCAN_DWELL cycles per frame; the frame length is 4*SCAN_DWELL.

Reset
REQ-023 While rst is high: cardSelect=0, red=0, green=0, cmd_ready=0, buffer empty, all card registers off, FSM in HOLD with count 0, blink phase=1.
REQ-024 cmd_ready SHALL rise on the first cycle after rst deasserts.
REQ-025 Reset mid-dwell or with the buffer full SHALL discard the pending command and restart the scan at card 0.

Configuration
REQ-026 The macro LED_BLINK_EN SHALL compile blink support in or out.
REQ-027 With LED_BLINK_EN defined, a free-running counter SHALL toggle phase every BLINK_DIV cycles.
REQ-028 Without LED_BLINK_EN, the counter and blink bits SHALL be absent, cmd_blink SHALL be ignored, and outputs SHALL always follow mode.
REQ-029 With LED_BLINK_EN, a card with blink=1 SHALL drive red=green=0 while phase=0.

Structure
REQ-030 Package led_pkg SHALL hold: NUM_CARDS=4, the mode encodings (MODE_OFF/RED/GREEN/BOTH), the scan-state enum, and the card-state struct typedef.
REQ-031 Sub-module led_blink_timer (counter plus phase output) SHALL be instantiated only under LED_BLINK_EN.

Verification
REQ-032 Reset release: outputs must be 0; cmd_ready=1 at cycle 1; cardSelect must sequence 0,0,0,0,1,1,1,1,2,... with SCAN_DWELL=4.
REQ-033 Command card=2, mode=01, blink=0: red=1 only while cardSelect=2, within 22 cycles; cards 0, 1 and 3 stay dark.
REQ-034 Back-to-back cmd_valid for cards 1 and 3: second held off (cmd_ready=0) until the first drains; both take effect, nothing dropped.
REQ-035 Card 0, mode=11, blink=1, BLINK_DIV=16 (LED_BLINK_EN): red/green on card 0 must be 1 in phase 1 and 0 in phase 0, toggling every 16 cycles; without the macro they stay 1.
REQ-036 rst asserted with the buffer full mid-dwell on card 3: after release, cardSelect=0, all LEDs off, and the discarded command never appears.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED scan sequencer.
// Build option: define LED_BLINK_EN to add a blink bit to each card state.
package led_pkg;

    localparam int NUM_CARDS = 4;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_RED   = 2'b01;
    localparam logic [1:0] MODE_GREEN = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    typedef enum logic {
        ST_HOLD    = 1'b0,
        ST_ADVANCE = 1'b1
    } scan_state_t;

    // mode[0] drives red, mode[1] drives green
    typedef struct packed {
        logic [1:0] mode;
`ifdef LED_BLINK_EN
        logic       blink;
`endif
    } card_state_t;

    localparam card_state_t CARD_OFF = '0;

    typedef struct packed {
        logic [1:0]  card;
        card_state_t st;
    } cmd_buf_t;

endpackage

// File: rtl/led_blink_timer.sv
// Free-running blink phase generator. Phase starts at 1 out of reset and
// toggles every BLINK_DIV cycles. Only instantiated when LED_BLINK_EN is defined.
module led_blink_timer #(
    parameter int BLINK_DIV = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_phase
);

    localparam logic [15:0] LP_RELOAD = 16'(BLINK_DIV - 1);

    logic [15:0] r_count;
    logic        r_phase;

    // down-counter, toggle phase and reload on terminal count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= LP_RELOAD;
            r_phase <= 1'b1;
        end else if (r_count == 16'd0) begin
            r_count <= LP_RELOAD;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/led_scan_sequencer.sv
// Multiplexed LED card scanner with a one-entry command buffer.
// Build option: LED_BLINK_EN compiles in per-card blink support.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_HOLD    | present current card, count SCAN_DWELL-1 cycles
//  ST_ADVANCE | one cycle; step to next card, drain command buffer
module led_scan_sequencer
    import led_pkg::*;
#(
    parameter int SCAN_DWELL = 4,
    parameter int BLINK_DIV  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_card,
    input  logic [1:0] cmd_mode,
    input  logic       cmd_blink,
    output logic [1:0] cardSelect,
    output logic       red,
    output logic       green
);

    localparam logic [7:0] LP_HOLD_LAST = 8'(SCAN_DWELL - 2);

    scan_state_t r_state;
    scan_state_t w_state_next;
    logic [7:0]  r_count;
    logic        r_ready_en;
    logic        r_buf_full;
    cmd_buf_t    r_buf;
    card_state_t r_cards [NUM_CARDS];
    logic [1:0]  r_card_sel;
    logic        r_red;
    logic        r_green;

    logic        w_hold_done;
    logic        w_accept;
    logic        w_advance;
    logic        w_drain;
    logic [1:0]  w_sel_next;
    card_state_t w_present;
    logic        w_red_next;
    logic        w_green_next;

`ifdef LED_BLINK_EN
    logic        w_phase;

    led_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .i_clk   (clk),
        .i_rst   (rst),
        .o_phase (w_phase)
    );
`else
    logic        w_unused_cfg;
    assign w_unused_cfg = ^{cmd_blink, 16'(BLINK_DIV)};
`endif

    assign w_hold_done = (r_count == LP_HOLD_LAST);
    assign cmd_ready   = r_ready_en & ~r_buf_full;
    assign w_accept    = cmd_valid & cmd_ready;

    // scan state and dwell counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HOLD;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_HOLD && !w_hold_done)
                r_count <= r_count + 8'd1;
            else
                r_count <= '0;
        end
    end

    // next scan state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD:    if (w_hold_done) w_state_next = ST_ADVANCE;
            ST_ADVANCE: w_state_next = ST_HOLD;
            default:    w_state_next = ST_HOLD;
        endcase
    end

    // card to present after this edge and its LED levels; a drain into that
    // same card is forwarded so the new value shows without a frame of delay
    always_comb begin
        w_advance  = (r_state == ST_ADVANCE);
        w_drain    = w_advance & r_buf_full;
        w_sel_next = w_advance ? r_card_sel + 2'd1 : r_card_sel;
        w_present  = r_cards[w_sel_next];
        if (w_drain && r_buf.card == w_sel_next)
            w_present = r_buf.st;
        w_red_next   = w_present.mode[0];
        w_green_next = w_present.mode[1];
`ifdef LED_BLINK_EN
        if (w_present.blink && !w_phase) begin
            w_red_next   = 1'b0;
            w_green_next = 1'b0;
        end
`endif
    end

    // hold cmd_ready low for the first cycle out of reset
    always_ff @(posedge clk) begin
        if (rst) r_ready_en <= 1'b0;
        else     r_ready_en <= 1'b1;
    end

    // one-entry command buffer; accept and drain never coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf      <= '0;
        end else if (w_drain) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf_full    <= 1'b1;
            r_buf.card    <= cmd_card;
            r_buf.st.mode <= cmd_mode;
`ifdef LED_BLINK_EN
            r_buf.st.blink <= cmd_blink;
`endif
        end
    end

    // per-card state registers, written only from the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CARDS; i++)
                r_cards[i] <= CARD_OFF;
        end else if (w_drain) begin
            r_cards[r_buf.card] <= r_buf.st;
        end
    end

    // select and LED levels registered together so they never skew
    always_ff @(posedge clk) begin
        if (rst) begin
            r_card_sel <= 2'd0;
            r_red      <= 1'b0;
            r_green    <= 1'b0;
        end else begin
            r_card_sel <= w_sel_next;
            r_red      <= w_red_next;
            r_green    <= w_green_next;
        end
    end

    assign cardSelect = r_card_sel;
    assign red        = r_red;
    assign green      = r_green;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Self-checking bench for led_scan_sequencer against a frame-level model.
module tb_led_scan_sequencer;

    localparam int D   = 4;
    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_card = 2'd0;
    logic [1:0] cmd_mode = 2'd0;
    logic       cmd_blink = 1'b0;
    logic [1:0] cardSelect;
    logic       red;
    logic       green;

    led_scan_sequencer #(
        .SCAN_DWELL (D),
        .BLINK_DIV  (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_card   (cmd_card),
        .cmd_mode   (cmd_mode),
        .cmd_blink  (cmd_blink),
        .cardSelect (cardSelect),
        .red        (red),
        .green      (green)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: k counts edges since the last edge that sampled reset
    int       k = 0;
    bit [1:0] m_mode  [4];
    bit       m_blink [4];
    bit       pend = 0;
    bit [1:0] p_card, p_mode;
    bit       p_blink;
    bit       acc;
    bit       exp_rdy = 0;
    int       e_sel;
    bit       e_red, e_green;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%0d expected=%0d", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        bit [1:0] st_mode;
        bit       st_blink;
        bit       ph;
        acc = 0;
        @(posedge clk);
        if (rst) begin
            k    = 0;
            pend = 0;
            for (int i = 0; i < 4; i++) begin
                m_mode[i]  = 2'd0;
                m_blink[i] = 1'b0;
            end
        end else begin
            k++;
            if (pend && (k % D == 0)) begin
                m_mode[p_card]  = p_mode;
                m_blink[p_card] = p_blink;
                pend = 0;
            end else if (cmd_valid && exp_rdy) begin
                pend    = 1;
                acc     = 1;
                p_card  = cmd_card;
                p_mode  = cmd_mode;
                p_blink = cmd_blink;
            end
        end
        exp_rdy = (k >= 1) && !pend;
        if (k == 0) begin
            e_sel = 0; e_red = 0; e_green = 0;
        end else begin
            e_sel    = (k / D) % 4;
            st_mode  = m_mode[e_sel];
            st_blink = m_blink[e_sel];
            ph       = (((k - 1) / DIV) % 2) == 0;
`ifdef LED_BLINK_EN
            e_red   = st_mode[0] && (!st_blink || ph);
            e_green = st_mode[1] && (!st_blink || ph);
`else
            e_red   = st_mode[0];
            e_green = st_mode[1];
`endif
        end
        #1;
        chk("cardSelect", int'(cardSelect), e_sel);
        chk("red",        int'(red),        int'(e_red));
        chk("green",      int'(green),      int'(e_green));
        chk("cmd_ready",  int'(cmd_ready),  int'(exp_rdy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input bit [1:0] c, input bit [1:0] m, input bit b);
        cmd_valid = 1; cmd_card = c; cmd_mode = m; cmd_blink = b;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc) break;
        end
        chk("send_accepted", int'(acc), 1);
        cmd_valid = 0;
    endtask

    initial begin
        // reset and free scan
        run(3);
        rst = 0;
        run(24);

        // single command to card 2, red only
        send(2'd2, 2'b01, 1'b0);
        run(40);

        // back-to-back commands; second waits for the first to drain
        send(2'd1, 2'b10, 1'b0);
        send(2'd3, 2'b11, 1'b0);
        // stray strobe while buffer is full must be ignored
        cmd_valid = 1; cmd_card = 2'd1; cmd_mode = 2'b00; cmd_blink = 1'b1;
        tick();
        cmd_valid = 0;
        run(40);

        // blinking card 0
        send(2'd0, 2'b11, 1'b1);
        run(100);

        // randomized commands with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_card  = 2'($urandom_range(0, 3));
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_blink = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 0; cmd_valid = 0;
        run(24);

        // populate cards, then reset with buffer full while on card 3
        send(2'd1, 2'b11, 1'b0);
        run(2 * 4 * D);
        for (int i = 0; i < 100; i++) begin
            if (((k / D) % 4 == 3) && (k % D == 0) && !pend) break;
            tick();
        end
        chk("reached_card3", (k / D) % 4, 3);
        send(2'd2, 2'b11, 1'b0);
        chk("buffer_full", int'(pend), 1);
        rst = 1;
        run(2);
        rst = 0;
        run(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
